// File: rtl/syn_fifo_pkg.sv
// Shared constants and pointer-width helper for the syn_fifo_flags FIFO.
package syn_fifo_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DEPTH     = 64;
  localparam int DEF_AF_MARGIN = 4;
  localparam int DEF_AE_THRESH = 4;

  // One extra bit beyond the address so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/syn_fifo_flags_mem.sv
// Simple dual-port storage for the FIFO: one write port, one read port with a
// registered, resettable output that holds its value when no read is issued.
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/syn_fifo_flags.sv
// Synchronous FIFO with exact registered occupancy flags and sticky error flags.
// Define SYN_FIFO_FWFT_EN for first-word-fall-through output; default is registered-read mode.
module syn_fifo_flags
  import syn_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      we,
  input  logic                      re,
  output logic [WIDTH-1:0]          rdata,
  output logic                      rvalid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [ptr_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      err_clr
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [31:0] AF_T = 32'(AF_THRESH);
  localparam logic [31:0] AE_T = 32'(AE_THRESH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic wr_acc, rd_acc, mem_we, mem_re;
  logic [WIDTH-1:0] mem_rdata;
  logic [31:0] count_ext;

  assign wr_acc = we && !full_q;
  assign rd_acc = re && !empty_q;

  always_comb begin
    count_d = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + PW'(1);
    else if (!wr_acc && rd_acc) count_d = count_q - PW'(1);
    count_ext = 32'(count_d);
    // Flags come from the next count so they change on the same edge as count.
    full_d  = (count_ext == 32'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_ext >= AF_T);
    ae_d    = (count_ext <= AE_T);
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (we && full_q)  ovf_d = 1'b1;
    if (re && empty_q) udf_d = 1'b1;
    wr_ptr_d = wr_ptr_q + PW'(mem_we);
    rd_ptr_d = rd_ptr_q + PW'(mem_re);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= (AF_THRESH == 0);
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef SYN_FIFO_FWFT_EN
  // Output stage is either a bypass register (word written while the stage
  // drains) or the memory read register; count covers both stage and memory.
  logic mem_empty, bypass, sel_q, sel_d;
  logic [WIDTH-1:0] byp_q, byp_d;

  assign mem_empty = (wr_ptr_q == rd_ptr_q);
  assign bypass    = wr_acc && (empty_q || (rd_acc && mem_empty));
  assign mem_we    = wr_acc && !bypass;
  assign mem_re    = rd_acc && !mem_empty;

  always_comb begin
    sel_d = sel_q;
    byp_d = byp_q;
    if (bypass) begin
      sel_d = 1'b1;
      byp_d = wdata;
    end else if (mem_re) begin
      sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= 1'b1;
      byp_q <= '0;
    end else begin
      sel_q <= sel_d;
      byp_q <= byp_d;
    end
  end

  assign rvalid = !empty_q;
  assign rdata  = sel_q ? byp_q : mem_rdata;
`else
  logic rvalid_q, rvalid_d;

  assign mem_we   = wr_acc;
  assign mem_re   = rd_acc;
  assign rvalid_d = rd_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rvalid_q <= 1'b0;
    else     rvalid_q <= rvalid_d;
  end

  assign rvalid = rvalid_q;
  assign rdata  = mem_rdata;
`endif

  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wdata),
    .re    (mem_re),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
